// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: two-wide instruction FIFO between selection and decode.
// Up to two instructions enter per cycle; the two oldest are presented to
// decode, which retires 0..2 per cycle. A flush empties the queue in one cycle.
// Optional feature macro: IFQ_STALL_CNT_EN builds a saturating counter of
// cycles in which an enqueue was attempted while the queue lacked two free
// entries. When the macro is undefined, o_stall_cnt is tied to zero.
module inst_fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_enq_vld_1,
  input  logic                    i_enq_vld_2,
  input  logic [31:0]             i_enq_inst_1,
  input  logic [31:0]             i_enq_inst_2,
  input  logic [31:0]             i_enq_pc,
  output logic                    o_enq_rdy,
  output logic                    o_deq_vld_1,
  output logic                    o_deq_vld_2,
  output logic [31:0]             o_deq_inst_1,
  output logic [31:0]             o_deq_inst_2,
  output logic [31:0]             o_deq_pc_1,
  output logic [31:0]             o_deq_pc_2,
  input  logic [1:0]              i_deq_cnt,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [31:0]             o_stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] count;
  logic [PW-1:0] enq_n;
  logic [AW-1:0] rd_idx_1, rd_idx_2;
  logic [AW-1:0] wr_idx_1, wr_idx_2;
  logic          enq_fire;

  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];

  // Occupancy, ready and read indices derived only from registered pointers.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    o_count  = count;
    o_enq_rdy = (count <= PW'(DEPTH - 2));
    enq_fire = i_enq_vld_1 && o_enq_rdy;
    enq_n    = '0;
    if (enq_fire) begin
      enq_n = i_enq_vld_2 ? PW'(2) : PW'(1);
    end
    rd_idx_1 = rd_ptr_q[AW-1:0];
    rd_idx_2 = rd_idx_1 + AW'(1);
    wr_idx_1 = wr_ptr_q[AW-1:0];
    wr_idx_2 = wr_idx_1 + AW'(1);
  end

  // Next pointer values; flush overrides both enqueue and dequeue.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(i_deq_cnt);
    wr_ptr_d = wr_ptr_q + enq_n;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry storage; contents are not reset, validity comes from the pointers.
  always_ff @(posedge i_clk) begin
    if (enq_fire && !i_flush) begin
      inst_q[wr_idx_1] <= i_enq_inst_1;
      pc_q[wr_idx_1]   <= i_enq_pc;
      if (i_enq_vld_2) begin
        inst_q[wr_idx_2] <= i_enq_inst_2;
        pc_q[wr_idx_2]   <= i_enq_pc + 32'd4;
      end
    end
  end

  // Decode-side view of the two oldest entries.
  always_comb begin
    o_deq_vld_1  = (count != '0);
    o_deq_vld_2  = (count >= PW'(2));
    o_deq_inst_1 = inst_q[rd_idx_1];
    o_deq_pc_1   = pc_q[rd_idx_1];
    o_deq_inst_2 = inst_q[rd_idx_2];
    o_deq_pc_2   = pc_q[rd_idx_2];
  end

`ifdef IFQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count attempted-but-refused enqueue cycles, holding at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_enq_vld_1 && !o_enq_rdy && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register; only reset clears it, flush leaves it alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
